// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_divider
// Summary  : Iterative restoring signed divider, 2W-bit / W-bit, one step per clk.
// Revision : 1.0
// ============================================================================
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DIV   = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 quot_neg_q, quot_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]     prem_q, prem_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [WIDTH-1:0]     dmag_q, dmag_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     quotient_q, quotient_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic [2*WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]     dvs_mag;
  logic [WIDTH:0]       trial_sh;
  logic [WIDTH:0]       trial_diff;
  logic                 q_too_big;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      prem_q      <= '0;
      shreg_q     <= '0;
      dmag_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quot_neg_q  <= quot_neg_d;
      rem_neg_q   <= rem_neg_d;
      prem_q      <= prem_d;
      shreg_q     <= shreg_d;
      dmag_q      <= dmag_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quot_neg_d  = quot_neg_q;
    rem_neg_d   = rem_neg_q;
    prem_d      = prem_q;
    shreg_d     = shreg_q;
    dmag_d      = dmag_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    // Unsigned magnitudes: the most negative values map onto their exact unsigned value.
    dvd_mag    = dvd_q[2*WIDTH-1] ? -dvd_q : dvd_q;
    dvs_mag    = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
    trial_sh   = {prem_q, shreg_q[WIDTH-1]};
    trial_diff = trial_sh - {1'b0, dmag_q};
    q_too_big  = quot_neg_q ? (shreg_q[WIDTH-1] & (|shreg_q[WIDTH-2:0]))
                            : shreg_q[WIDTH-1];

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d       = dividend;
          dvs_d       = divisor;
          quot_neg_d  = dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
          rem_neg_d   = dividend[2*WIDTH-1];
          quotient_d  = '0;
          remainder_d = '0;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        // Early-exit cases pass through FIX so every result leaves via one registered stage.
        if (dvs_q == '0) begin
          dbz_d       = 1'b1;
          remainder_d = dvd_q[WIDTH-1:0];
          state_d     = S_FIX;
        end else if (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag) begin
          ovf_d   = 1'b1;
          state_d = S_FIX;
        end else begin
          prem_d  = dvd_mag[2*WIDTH-1:WIDTH];
          shreg_d = dvd_mag[WIDTH-1:0];
          dmag_d  = dvs_mag;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // Low dividend bits shift out of shreg while quotient bits shift in behind them.
        if (!trial_diff[WIDTH]) begin
          prem_d  = trial_diff[WIDTH-1:0];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d  = trial_sh[WIDTH-1:0];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (!(dbz_q || ovf_q)) begin
          if (q_too_big) begin
            ovf_d = 1'b1;
          end else begin
            quotient_d  = quot_neg_q ? -shreg_q : shreg_q;
            remainder_d = rem_neg_q ? -prem_q : prem_q;
          end
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire
